// File: rtl/cell_sweep_driver_if.sv
// -----------------------------------------------------------------------------
// cell_sweep_driver_if
// Signal bundle between a cell sweep driver and whoever controls it and hosts
// the cell under test.
//
//   start          request a sweep (controller -> driver)
//   dut_in         cell output ZN (cell -> driver)
//   vec_out        pattern driven to the cell, MSB = A1 (driver -> cell)
//   busy, done     sweep in progress / one-cycle end-of-sweep pulse
//   pass, err_cnt  result of the last sweep
//   first_fail_*   first mismatching pattern and its valid flag
//
// Modports: master = controller/cell side, slave = the sweep driver.
// -----------------------------------------------------------------------------
interface cell_sweep_driver_if #(
  parameter int N_IN = 3
);
  logic            start;
  logic [N_IN-1:0] vec_out;
  logic            dut_in;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_cnt;
  logic            first_fail_vld;
  logic [N_IN-1:0] first_fail_idx;

  modport master (
    output start, dut_in,
    input  vec_out, busy, done, pass, err_cnt, first_fail_vld, first_fail_idx
  );

  modport slave (
    input  start, dut_in,
    output vec_out, busy, done, pass, err_cnt, first_fail_vld, first_fail_idx
  );
endinterface

// File: rtl/cell_sweep_driver.sv
// -----------------------------------------------------------------------------
// cell_sweep_driver
// Walks every input pattern of a small combinational cell in ascending order,
// holds each one for SETTLE+1 cycles, samples the cell output on the last of
// those edges and compares it against the expected truth table EXP_TT.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   cell_sweep_driver_if.slave (start, dut_in in; vec_out, busy, done,
//         pass, err_cnt, first_fail_vld, first_fail_idx out)
//
// Parameters:
//   N_IN    number of cell inputs (1..6)
//   SETTLE  extra hold cycles per pattern before sampling (0..15)
//   EXP_TT  expected truth table, bit i = expected output for pattern i
//
// Optional: define SWEEP_LOG_EN to print one simulation line per sampled
// pattern and one per completed sweep. Function is identical either way.
// -----------------------------------------------------------------------------
module cell_sweep_driver #(
  parameter int                  N_IN   = 3,
  parameter int                  SETTLE = 2,
  parameter logic [2**N_IN-1:0]  EXP_TT = 8'hFE
) (
  input  logic                clk,
  input  logic                rst,
  cell_sweep_driver_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

  localparam int              CW         = N_IN + 1;
  localparam logic [N_IN-1:0] LAST_PAT   = '1;
  localparam logic [3:0]      SETTLE_CNT = 4'(SETTLE);

  state_t          state, state_nxt;
  logic [3:0]      hold_cnt;
  logic            sample;
  logic            last_pat;
  logic            mismatch;
  logic [CW-1:0]   err_cnt_inc;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: state elements use non-blocking assignments so every flop updates
  // from the values present before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next state, status outputs and compare logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    sample    = (state == HOLD) && (hold_cnt == 4'd0);
    last_pat  = (bus.vec_out == LAST_PAT);
    // Case-inequality: an X or Z from the cell is a failure, never a match.
    mismatch  = sample && (bus.dut_in !== EXP_TT[bus.vec_out]);
    err_cnt_inc = bus.err_cnt + CW'(mismatch);
    bus.busy  = (state == HOLD);
    bus.done  = (state == DONE);

    case (state)
      IDLE:    if (bus.start)         state_nxt = HOLD;
      HOLD:    if (sample && last_pat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pattern walker, hold counter and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.vec_out        <= '0;
      bus.err_cnt        <= '0;
      bus.first_fail_vld <= 1'b0;
      bus.first_fail_idx <= '0;
      bus.pass           <= 1'b0;
      hold_cnt           <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.vec_out        <= '0;
            bus.err_cnt        <= '0;
            bus.first_fail_vld <= 1'b0;
            bus.first_fail_idx <= '0;
            bus.pass           <= 1'b0;
            hold_cnt           <= SETTLE_CNT;
          end
        end
        HOLD: begin
          if (hold_cnt != 4'd0) begin
            hold_cnt <= hold_cnt - 4'd1;
          end else begin
            bus.err_cnt <= err_cnt_inc;
            if (mismatch && !bus.first_fail_vld) begin
              bus.first_fail_vld <= 1'b1;
              bus.first_fail_idx <= bus.vec_out;
            end
            if (!last_pat) begin
              bus.vec_out <= bus.vec_out + 1'b1;
              hold_cnt    <= SETTLE_CNT;
            end else begin
              // Pass is resolved on the final sample edge so it already
              // includes the last pattern while done is high.
              bus.pass <= (err_cnt_inc == '0);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SWEEP_LOG_EN
`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && sample)
      $display("%b: %b exp %b", bus.vec_out, bus.dut_in, EXP_TT[bus.vec_out]);
    if (!rst && state == DONE)
      $display("sweep pass=%0d errors=%0d", bus.pass, bus.err_cnt);
  end
`endif
`else
  // Logging disabled: nothing extra is elaborated.
`endif

endmodule

// File: tb/tb_cell_sweep_driver.sv
// -----------------------------------------------------------------------------
// tb_cell_sweep_driver
// Two driver instances: the default OR3 configuration and an OR2 build with
// SETTLE=0. A cell model maps vec_out to dut_in through a per-sweep truth
// table (with optional X positions). Expected sweep results come from a
// pattern-by-pattern comparison of that table against the expected function
// and are queued at start; monitors pop and compare whenever done pulses.
// -----------------------------------------------------------------------------
module tb_cell_sweep_driver;

  localparam logic [7:0] EXP0 = 8'hFE;
  localparam logic [3:0] EXP1 = 4'b1110;
  localparam int         LAT0 = 8 * 3;   // 2**3 patterns * (SETTLE+1)
  localparam int         LAT1 = 4 * 1;   // 2**2 patterns * 1

  typedef struct {
    int err;
    bit ffv;
    int ffi;
    bit pass;
    int done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cell_sweep_driver_if #(.N_IN(3)) bus0 ();
  cell_sweep_driver_if #(.N_IN(2)) bus1 ();

  cell_sweep_driver dut0 (.clk(clk), .rst(rst), .bus(bus0));
  cell_sweep_driver #(.N_IN(2), .SETTLE(0), .EXP_TT(4'b1110))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Cell models: output looked up from the pattern currently driven.
  logic [7:0] drv0 = 8'hFE;
  logic [3:0] drv1 = 4'b1110;
  assign bus0.dut_in = drv0[bus0.vec_out];
  assign bus1.dut_in = drv1[bus1.vec_out];

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  exp_t q0[$];
  exp_t q1[$];
  bit   four_state;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no done within cycle budget (cycle %0d)", name, cyc);
  endtask

  // ---------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (bus0.done === 1'b1) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0 unexpected done at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = q0.pop_front();
        check("dut0 err_cnt",        32'(bus0.err_cnt),        32'(e.err));
        check("dut0 first_fail_vld", 32'(bus0.first_fail_vld), 32'(e.ffv));
        check("dut0 first_fail_idx", 32'(bus0.first_fail_idx), 32'(e.ffi));
        check("dut0 pass",           32'(bus0.pass),           32'(e.pass));
        check("dut0 done latency",   32'(cyc),                 32'(e.done_cyc));
        check("dut0 vec_out at end", 32'(bus0.vec_out),        32'd7);
        check("dut0 busy in done",   32'(bus0.busy),           32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (bus1.done === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1 unexpected done at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("dut1 err_cnt",      32'(bus1.err_cnt), 32'(e.err));
        check("dut1 pass",         32'(bus1.pass),    32'(e.pass));
        check("dut1 done latency", 32'(cyc),          32'(e.done_cyc));
        check("dut1 vec_out end",  32'(bus1.vec_out), 32'd3);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // One sweep on dut0 with cell truth table tt; xm marks patterns where the
  // cell output is unknown. On two-state simulators X cannot be carried, so
  // the complement of the expected bit stands in and stays a mismatch.
  // ---------------------------------------------------------------------------
  task automatic sweep0(input logic [7:0] tt, input logic [7:0] xm);
    exp_t       e;
    logic [7:0] d;
    int         n;
    e.err = 0; e.ffv = 0; e.ffi = 0;
    for (int i = 0; i < 8; i++) begin
      d[i] = xm[i] ? (four_state ? 1'bx : ~EXP0[i]) : tt[i];
      if (xm[i] || (tt[i] != EXP0[i])) begin
        if (!e.ffv) begin e.ffv = 1; e.ffi = i; end
        e.err++;
      end
    end
    e.pass = (e.err == 0);

    @(negedge clk);
    drv0 = d;
    bus0.start = 1'b1;
    e.done_cyc = cyc + 1 + LAT0;
    q0.push_back(e);
    @(negedge clk);
    bus0.start = 1'b0;
    n = 0;
    while (bus0.done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus0.done !== 1'b1) begin
      timeout_fail("dut0 sweep");
      q0.delete();
    end else begin
      repeat (3) @(negedge clk);
      check("dut0 idle hold err_cnt", 32'(bus0.err_cnt), 32'(e.err));
      check("dut0 idle hold pass",    32'(bus0.pass),    32'(e.pass));
      check("dut0 idle busy",         32'(bus0.busy),    32'd0);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic probe;
    int   c0;
    int   n;
    exp_t e;

    probe = 1'bx;
    four_state = $isunknown(probe);

    rst = 1'b1;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    repeat (3) @(negedge clk);
    check("dut0 reset outputs",
          {bus0.vec_out, bus0.busy, bus0.done, bus0.pass, bus0.err_cnt,
           bus0.first_fail_vld, bus0.first_fail_idx}, 32'd0);
    check("dut1 reset outputs",
          {bus1.vec_out, bus1.busy, bus1.done, bus1.pass, bus1.err_cnt,
           bus1.first_fail_vld, bus1.first_fail_idx}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    sweep0(8'hFE, 8'h00);           // ideal OR3
    sweep0(8'h00, 8'h00);           // stuck at 0
    sweep0(8'hFF, 8'h00);           // stuck at 1
    sweep0(8'hFE, 8'b0010_0000);    // X on pattern 101 only
    for (int k = 0; k < 6; k++)     // random faulty cells, sparse X
      sweep0(8'($urandom), 8'($urandom & $urandom & $urandom));

    // start held high throughout a sweep, then reset while pattern 100 is up.
    @(negedge clk);
    drv0 = 8'hFE;
    bus0.start = 1'b1;
    c0 = cyc;
    n = 0;
    @(negedge clk);
    while (bus0.vec_out !== 3'b100 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus0.vec_out !== 3'b100) timeout_fail("dut0 reach pattern 100");
    else check("dut0 restart ignored (pattern 100 timing)", 32'(cyc), 32'(c0 + 1 + 12));
    rst = 1'b1;
    #1;
    check("dut0 outputs after async rst",
          {bus0.vec_out, bus0.busy, bus0.done, bus0.pass, bus0.err_cnt,
           bus0.first_fail_vld, bus0.first_fail_idx}, 32'd0);
    bus0.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("dut0 stays idle after rst", {bus0.busy, bus0.vec_out}, 32'd0);

    sweep0(8'hFE, 8'h00);           // fresh sweep after reset

    // OR2, SETTLE=0 instance.
    e.err = 0; e.ffv = 0; e.ffi = 0;
    for (int i = 0; i < 4; i++) if (drv1[i] != EXP1[i]) e.err++;
    e.pass = (e.err == 0);
    @(negedge clk);
    bus1.start = 1'b1;
    e.done_cyc = cyc + 1 + LAT1;
    q1.push_back(e);
    @(negedge clk);
    bus1.start = 1'b0;
    n = 0;
    while (bus1.done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus1.done !== 1'b1) begin
      timeout_fail("dut1 sweep");
      q1.delete();
    end

    repeat (4) @(negedge clk);
    check("dut0 scoreboard drained", 32'(q0.size()), 32'd0);
    check("dut1 scoreboard drained", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
